// File: rtl/alu_issue_stage.sv
// RV32I decode-and-issue register feeding the ALU; 1-cycle latency from accept to out_valid.
// Backpressure: in_ready = !out_valid | out_ready; flush drops both held and incoming bundles.
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instruction,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic            cin,
    output logic [3:0]      opcode,
    output logic            branch,
    output logic [31:0]     instruction,
    output logic            illegal
);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_ADD  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_BRC  = 4'b1010;
    localparam logic [3:0] ALU_PASS = 4'b1111;

    localparam logic [6:0] MAJ_OP     = 7'b0110011;
    localparam logic [6:0] MAJ_OP_IMM = 7'b0010011;
    localparam logic [6:0] MAJ_LOAD   = 7'b0000011;
    localparam logic [6:0] MAJ_STORE  = 7'b0100011;
    localparam logic [6:0] MAJ_BRANCH = 7'b1100011;
    localparam logic [6:0] MAJ_LUI    = 7'b0110111;
    localparam logic [6:0] MAJ_AUIPC  = 7'b0010111;
    localparam logic [6:0] MAJ_JAL    = 7'b1101111;
    localparam logic [6:0] MAJ_JALR   = 7'b1100111;

    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic            cin;
        logic [3:0]      opcode;
        logic            branch;
        logic [31:0]     instruction;
        logic            illegal;
    } issue_t;

    localparam issue_t RESET_BUNDLE = '{
        a: '0, b: '0, cin: 1'b0, opcode: ALU_PASS,
        branch: 1'b0, instruction: 32'h0000_0013, illegal: 1'b0
    };

    function automatic logic [3:0] f3_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [6:0]      maj;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;
    logic            bad;
    issue_t          dec;

    assign maj    = in_instruction[6:0];
    assign funct3 = in_instruction[14:12];
    assign funct7 = in_instruction[31:25];
    assign imm_i  = {{20{in_instruction[31]}}, in_instruction[31:20]};
    assign imm_s  = {{20{in_instruction[31]}}, in_instruction[31:25], in_instruction[11:7]};
    assign imm_u  = {in_instruction[31:12], 12'b0};
    assign shamt  = {27'b0, in_instruction[24:20]};

    always_comb begin
        dec             = RESET_BUNDLE;
        dec.instruction = in_instruction;
        bad             = 1'b0;
        case (maj)
            MAJ_OP: begin
                dec.a = in_rs1_data;
                dec.b = in_rs2_data;
                if (funct7 == 7'b0)
                    dec.opcode = f3_op(funct3, 1'b0);
                else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))
                    dec.opcode = f3_op(funct3, 1'b1);
                else
                    bad = 1'b1;
                // Subtract runs on the adder as rs1 + ~rs2 + 1.
                if (dec.opcode == ALU_SUB) begin
                    dec.b   = ~in_rs2_data;
                    dec.cin = 1'b1;
                end
            end
            MAJ_OP_IMM: begin
                dec.a      = in_rs1_data;
                dec.b      = imm_i;
                dec.opcode = f3_op(funct3, 1'b0);
                if (funct3 == 3'b001) begin
                    dec.b = shamt;
                    bad   = (funct7 != 7'b0);
                end else if (funct3 == 3'b101) begin
                    dec.b = shamt;
                    if (funct7 == F7_ALT)
                        dec.opcode = ALU_SRA;
                    else
                        bad = (funct7 != 7'b0);
                end
            end
            MAJ_LOAD: begin
                dec.a      = in_rs1_data;
                dec.b      = imm_i;
                dec.opcode = ALU_ADD;
            end
            MAJ_STORE: begin
                dec.a      = in_rs1_data;
                dec.b      = imm_s;
                dec.opcode = ALU_ADD;
            end
            MAJ_BRANCH: begin
                dec.a      = in_rs1_data;
                dec.b      = in_rs2_data;
                dec.opcode = ALU_BRC;
                dec.branch = 1'b1;
                bad        = (funct3 == 3'b010 || funct3 == 3'b011);
            end
            MAJ_LUI: begin
                dec.b = imm_u;
            end
            MAJ_AUIPC: begin
                dec.a      = in_pc;
                dec.b      = imm_u;
                dec.opcode = ALU_ADD;
            end
            MAJ_JAL, MAJ_JALR: begin
                dec.a      = in_pc;
                dec.b      = 32'd4;
                dec.opcode = ALU_ADD;
            end
            default: bad = 1'b1;
        endcase
        // Illegal encodings still issue so execute can raise the trap.
        if (bad) begin
            dec.a       = '0;
            dec.b       = '0;
            dec.cin     = 1'b0;
            dec.opcode  = ALU_PASS;
            dec.branch  = 1'b0;
            dec.illegal = 1'b1;
        end
    end

    logic   out_valid_q, out_valid_d;
    issue_t bundle_q, bundle_d;
    logic   accept;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            bundle_d    = dec;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            bundle_q    <= RESET_BUNDLE;
        end else begin
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign a           = bundle_q.a;
    assign b           = bundle_q.b;
    assign cin         = bundle_q.cin;
    assign opcode      = bundle_q.opcode;
    assign branch      = bundle_q.branch;
    assign instruction = bundle_q.instruction;
    assign illegal     = bundle_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vector table plus stall, flush and reset sequences.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instruction, in_pc, in_rs1_data, in_rs2_data;
    logic [31:0] a, b, instruction;
    logic        cin, branch, illegal;
    logic [3:0]  opcode;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instruction(in_instruction), .in_pc(in_pc),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .b(b), .cin(cin), .opcode(opcode), .branch(branch),
        .instruction(instruction), .illegal(illegal)
    );

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        exp_cin;
        logic [3:0]  exp_op;
        logic        exp_branch;
        logic        exp_illegal;
    } vec_t;

    // {valid, illegal, branch, cin, opcode, a, b, instruction}
    function automatic logic [103:0] pack(input logic v, input logic ill, input logic br,
                                          input logic c, input logic [3:0] op,
                                          input logic [31:0] va, input logic [31:0] vb,
                                          input logic [31:0] ins);
        return {v, ill, br, c, op, va, vb, ins};
    endfunction

    function automatic logic [103:0] dut_bundle();
        return {out_valid, illegal, branch, cin, opcode, a, b, instruction};
    endfunction

    task automatic check(input string name, input logic [103:0] act, input logic [103:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
        in_valid       = v;
        in_instruction = ins;
        out_ready      = ordy;
        flush          = fl;
    endtask

    localparam logic [31:0] RS1 = 32'd5;
    localparam logic [31:0] RS2 = 32'd7;
    localparam logic [31:0] PC  = 32'h0000_0100;
    localparam logic [31:0] NOP = 32'h0000_0013;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"add",      32'h002081B3, RS1,   32'd7,        1'b0, 4'b0011, 1'b0, 1'b0});
        vecs.push_back('{"sub",      32'h402081B3, RS1,   32'hFFFFFFF8, 1'b1, 4'b0100, 1'b0, 1'b0});
        vecs.push_back('{"srai",     32'h4030D093, RS1,   32'd3,        1'b0, 4'b1001, 1'b0, 1'b0});
        vecs.push_back('{"beq",      32'h00208463, RS1,   RS2,          1'b0, 4'b1010, 1'b1, 1'b0});
        vecs.push_back('{"lui",      32'h123450B7, 32'd0, 32'h12345000, 1'b0, 4'b1111, 1'b0, 1'b0});
        vecs.push_back('{"undef",    32'h0000007F, 32'd0, 32'd0,        1'b0, 4'b1111, 1'b0, 1'b1});
        vecs.push_back('{"addi_m1",  32'hFFF08093, RS1,   32'hFFFFFFFF, 1'b0, 4'b0011, 1'b0, 1'b0});
        vecs.push_back('{"sw",       32'h0020A423, RS1,   32'd8,        1'b0, 4'b0011, 1'b0, 1'b0});
        vecs.push_back('{"lw_m4",    32'hFFC12083, RS1,   32'hFFFFFFFC, 1'b0, 4'b0011, 1'b0, 1'b0});
        vecs.push_back('{"auipc",    32'h00001097, PC,    32'h00001000, 1'b0, 4'b0011, 1'b0, 1'b0});
        vecs.push_back('{"jal",      32'h000000EF, PC,    32'd4,        1'b0, 4'b0011, 1'b0, 1'b0});
        vecs.push_back('{"op_f7bad", 32'h022081B3, 32'd0, 32'd0,        1'b0, 4'b1111, 1'b0, 1'b1});
        vecs.push_back('{"slli_bad", 32'h40309093, 32'd0, 32'd0,        1'b0, 4'b1111, 1'b0, 1'b1});
        vecs.push_back('{"blt",      32'h0020C463, RS1,   RS2,          1'b0, 4'b1010, 1'b1, 1'b0});
        vecs.push_back('{"br_f3bad", 32'h0020A463, 32'd0, 32'd0,        1'b0, 4'b1111, 1'b0, 1'b1});
        vecs.push_back('{"sltu",     32'h0020B1B3, RS1,   RS2,          1'b0, 4'b0110, 1'b0, 1'b0});
        vecs.push_back('{"srl",      32'h0020D1B3, RS1,   RS2,          1'b0, 4'b1000, 1'b0, 1'b0});
        vecs.push_back('{"sra",      32'h4020D1B3, RS1,   RS2,          1'b0, 4'b1001, 1'b0, 1'b0});
        vecs.push_back('{"andi",     32'h0F00F093, RS1,   32'h000000F0, 1'b0, 4'b0000, 1'b0, 1'b0});

        in_pc = PC; in_rs1_data = RS1; in_rs2_data = RS2;
        reset = 1'b1;
        drive(1'b0, NOP, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_state", dut_bundle(), pack(1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 32'd0, 32'd0, NOP));
        check("reset_in_ready", {103'd0, in_ready}, 104'd1);

        // Back-to-back issue with out_ready held high: one bundle per cycle.
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].inst, 1'b1, 1'b0);
            @(negedge clk);
            check(vecs[i].name, dut_bundle(),
                  pack(1'b1, vecs[i].exp_illegal, vecs[i].exp_branch, vecs[i].exp_cin,
                       vecs[i].exp_op, vecs[i].exp_a, vecs[i].exp_b, vecs[i].inst));
        end

        // Drain with no new input: valid drops, data held.
        drive(1'b0, 32'h002081B3, 1'b1, 1'b0);
        @(negedge clk);
        check("drain", dut_bundle(),
              pack(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, RS1, 32'h000000F0, 32'h0F00F093));

        // Stall: held add must stay put while sub waits at the input.
        drive(1'b1, 32'h002081B3, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h402081B3, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_in_ready", {103'd0, in_ready}, 104'd0);
            @(negedge clk);
            check("stall_hold", dut_bundle(),
                  pack(1'b1, 1'b0, 1'b0, 1'b0, 4'b0011, RS1, RS2, 32'h002081B3));
        end
        out_ready = 1'b1;
        #1;
        check("unstall_in_ready", {103'd0, in_ready}, 104'd1);
        @(negedge clk);
        check("after_stall", dut_bundle(),
              pack(1'b1, 1'b0, 1'b0, 1'b1, 4'b0100, RS1, 32'hFFFFFFF8, 32'h402081B3));
        drive(1'b0, NOP, 1'b1, 1'b0);
        @(negedge clk);
        check("no_duplicate", {103'd0, out_valid}, 104'd0);

        // Flush together with an accept while a bundle is held.
        drive(1'b1, 32'h002081B3, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h123450B7, 1'b1, 1'b1);
        #1;
        check("flush_in_ready", {103'd0, in_ready}, 104'd1);
        @(negedge clk);
        check("flush_drop", dut_bundle(),
              pack(1'b0, 1'b0, 1'b0, 1'b0, 4'b0011, RS1, RS2, 32'h002081B3));
        drive(1'b1, 32'h123450B7, 1'b1, 1'b0);
        @(negedge clk);
        check("post_flush", dut_bundle(),
              pack(1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 32'd0, 32'h12345000, 32'h123450B7));

        // Reset while stalled discards the held bundle.
        drive(1'b1, 32'h00208463, 1'b0, 1'b0);
        @(negedge clk);
        check("pre_reset_hold", dut_bundle(),
              pack(1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 32'd0, 32'h12345000, 32'h123450B7));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_mid_stall", dut_bundle(),
              pack(1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 32'd0, 32'd0, NOP));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
